// File: rtl/led_gen_pkg.sv
// Shared mode/direction encodings and pattern seeds for the LED pattern generator.
package led_gen_pkg;

    typedef logic [1:0] led_mode_t;

    localparam led_mode_t MODE_FILL   = 2'd0;
    localparam led_mode_t MODE_RUN_L  = 2'd1;
    localparam led_mode_t MODE_BOUNCE = 2'd2;
    localparam led_mode_t MODE_COUNT  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Seed pattern for a mode, at full 32-bit width; callers truncate to LED_W.
    function automatic logic [31:0] mode_seed(input led_mode_t m);
        logic [31:0] s;
        s = 32'd0;
        case (m)
            MODE_FILL:   s = 32'hFFFF_FFFF;
            MODE_RUN_L:  s = 32'd1;
            MODE_BOUNCE: s = 32'd1;
            MODE_COUNT:  s = 32'd0;
            default:     s = 32'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Step divider: emits a one-cycle step every TICK_DIV enabled clocks; clr restarts the count.
module led_tick_div #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // A clear on the wrap edge suppresses the step: the mode change wins.
    assign step = en & ~clr & w_wrap;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer (fill / running light / bounce / count) with optional PWM dimming
// enabled by defining LED_GEN_PWM_EN.
module led_pattern_gen #(
    parameter int unsigned LED_W    = 4,
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef LED_GEN_PWM_EN
    input  logic [7:0]       duty,
`endif
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic             dir
);

    import led_gen_pkg::*;

    led_mode_t        r_mode;
    logic [LED_W-1:0] r_led;
    logic             r_dir;
    logic             r_tick;

    logic             w_mode_chg;
    logic             w_step;
    logic [LED_W-1:0] w_seed_new;
    logic [LED_W-1:0] w_seed_cur;
    logic [LED_W-1:0] w_led_next;
    logic             w_dir_next;
    logic             w_pwm_on;

    assign w_mode_chg = (mode != r_mode);
    assign w_seed_new = LED_W'(mode_seed(mode));
    assign w_seed_cur = LED_W'(mode_seed(r_mode));

    led_tick_div #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (w_mode_chg),
        .step  (w_step)
    );

    // Next pattern for a step; an all-zero led in a one-hot mode reloads the seed.
    always_comb begin
        w_led_next = r_led;
        w_dir_next = r_dir;
        case (r_mode)
            MODE_FILL: begin
                if (r_led == '0) w_led_next = '1;
                else             w_led_next = r_led << 1;
            end
            MODE_RUN_L: begin
                if (r_led == '0) w_led_next = w_seed_cur;
                else             w_led_next = {r_led[LED_W-2:0], r_led[LED_W-1]};
            end
            MODE_BOUNCE: begin
                if (r_led == '0) begin
                    w_led_next = w_seed_cur;
                    w_dir_next = DIR_LEFT;
                end else if (r_dir == DIR_LEFT) begin
                    w_led_next = r_led << 1;
                    if (w_led_next[LED_W-1]) w_dir_next = DIR_RIGHT;
                end else begin
                    w_led_next = r_led >> 1;
                    if (w_led_next[0]) w_dir_next = DIR_LEFT;
                end
            end
            MODE_COUNT: begin
                w_led_next = r_led + 1'b1;
            end
            default: begin
                w_led_next = r_led;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_FILL;
            r_led  <= '1;
            r_dir  <= DIR_LEFT;
            r_tick <= 1'b0;
        end else if (w_mode_chg) begin
            r_mode <= mode;
            r_led  <= w_seed_new;
            r_dir  <= DIR_LEFT;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_step;
            if (w_step) begin
                r_led <= w_led_next;
                r_dir <= w_dir_next;
            end
        end
    end

`ifdef LED_GEN_PWM_EN
    logic [7:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pwm_cnt <= '0;
        else        r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end

    assign w_pwm_on = (r_pwm_cnt < duty);
`else
    assign w_pwm_on = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < LED_W; gi++) begin : g_led_gate
            assign led[gi] = r_led[gi] & w_pwm_on;
        end
    endgenerate

    assign tick = r_tick;
    assign dir  = r_dir;

endmodule
